mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between instruction fetch and the load/store unit. Fetch issues requests at the PC address, and the load/store unit issues data accesses. The block arbitrates per transaction, forwards the grant handshake combinationally and tracks exactly one outstanding transaction. It routes the response back to its owner. Data accesses have priority, but a streak counter bounds fetch starvation.

## Interface
- XLEN, 32, address/data width
- MAX_LS_STREAK, 4, consecutive load/store grants allowed while fetch waits (1..7)

- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held stable with if_addr until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  XLEN  fetched instruction
- ls_req  in  1  data request; held stable with ls_we/ls_be/ls_addr/ls_wdata until ls_gnt
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_addr  in  XLEN  data address
- ls_wdata  in  XLEN  store data
- ls_gnt  out  1  data request accepted
- ls_rvalid  out  1  data response valid (loads and stores)
- ls_rdata  out  XLEN  load data
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/4/XLEN/XLEN  memory request channel
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  response valid; exactly one per accepted request, including stores
- mem_rdata  in  XLEN  response data
- stray_rvalid  out  1  one-cycle pulse: mem_rvalid seen with nothing outstanding

## Operation
- States: IDLE, WAIT_IF, WAIT_LS. Reset enters IDLE.
- Behaviour in IDLE:
  - Selection is combinational. If a request is locked, select the locked owner.
  - Otherwise select LS when ls_req && (!if_req || streak < MAX_LS_STREAK).
  - Otherwise select IF when if_req.
  - Otherwise select nothing.
- Request channel:
  - mem_req equals the selected requester's req. mem_addr/we/be/wdata are muxed from the owner.
  - Fetch drives we=0, be=4'hF, wdata=0.
  - With no owner, all mem_* outputs are 0.
- Lock: when mem_req && !mem_gnt, register the owner. Selection stays with that owner until the grant, even if the other requester gains priority meanwhile.
- Grant: the owner's gnt = mem_req && mem_gnt, and the other gnt is 0. On the grant, go to WAIT_IF or WAIT_LS and clear the lock.
- WAIT_x: mem_req=0 and both gnt=0. When mem_rvalid arrives:
  - Assert x_rvalid=1 and set x_rdata=mem_rdata.
  - The other rdata stays 0.
  - Return to IDLE next cycle.
- Streak counter, 3 bits:
  - On an LS grant with if_req=1, increment, saturating at MAX_LS_STREAK.
  - On an LS grant with if_req=0, hold.
  - On an IF grant, clear to 0.
- Stray response: mem_rvalid in IDLE is not forwarded (both rvalid=0), and stray_rvalid pulses for that cycle.

## Timing
- Reset values:
  - All outputs are 0.
  - The state is IDLE, the lock is cleared and streak=0.
- Asserting rstn mid-transaction drops the outstanding transaction. A later response for it is flagged as stray and not forwarded.
- Latency:
  - The path from request to mem_req is combinational, with 0 cycles.
  - The path from mem_gnt to x_gnt is combinational.
  - The path from mem_rvalid to x_rvalid and rdata is combinational.
- Issue pacing: with a grant in cycle N, the earliest response is N+1. The earliest next mem_req is N+2 if the response arrives in N+1; otherwise it is the cycle after the response.
- Peak throughput is one transaction per 2 cycles.
- Simultaneous if_req and ls_req with streak < MAX select LS. With streak == MAX, they select IF.
- A requester dropping req before its grant is a protocol violation, and its behaviour is undefined. The lock prevents the arbiter itself from switching owner.

## Test plan
- Fetch only: if_req=1 with if_addr=0x100, 0x104, …, memory gnt=1 and rvalid one cycle later.
  - Required: a grant every 2 cycles, if_rdata matches the memory model, ls_* stay 0.
- Store: ls_req, ls_we=1, ls_be=4'b0011, ls_addr=0x2000, ls_wdata=0xDEADBEEF.
  - Required: mem_* carry exactly those values in the grant cycle, and ls_rvalid is 1 when the response arrives.
- Starvation bound: if_req and ls_req held high continuously with MAX_LS_STREAK=4.
  - Required: the grant sequence is LS,LS,LS,LS,IF repeating.
- Lock: mem_gnt=0 for 3 cycles while IF is selected with streak=0 and ls_req=0, then ls_req rises.
  - Required: mem_addr stays at the fetch address, and the IF grant is given first.
- Reset mid-transaction: assert rstn=0 in WAIT_LS, release, then mem_rvalid=1.
  - Required: ls_rvalid=0 and stray_rvalid=1 for one cycle. All outputs are 0 during reset.
- Slow memory: response delayed 5 cycles with both requests pending.
  - Required: mem_req=0 throughout WAIT, and only the owner's rvalid asserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory channels of the shared memory port.
interface mem_port_arbiter_if #(parameter int XLEN = 32);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req;
  logic            ls_we;
  logic [3:0]      ls_be;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            stray_rvalid;
  // master is the arbiter itself; slave is the environment (requesters and memory)
  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, stray_rvalid
  );
  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, stray_rvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight,
// load/store priority with a saturating streak counter bounding fetch starvation.
module mem_port_arbiter #(
  parameter int XLEN          = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input logic                clk,
  input logic                rstn,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS} state_t;
  localparam logic [2:0] MAX = 3'(MAX_LS_STREAK);
  state_t          state, state_nx;
  logic            locked, locked_nx, lock_ls, lock_ls_nx;
  logic [2:0]      streak, streak_nx;
  logic            idle, pick_ls, sel_ls, sel_if, req, grant;
  logic [XLEN-1:0] addr_mux, wdata_mux;
  // gating with rstn keeps every output at 0 while reset is held
  assign idle      = rstn && state == IDLE;
  assign pick_ls   = bus.ls_req && (!bus.if_req || streak < MAX);
  assign sel_ls    = idle && (locked ? lock_ls : pick_ls);
  assign sel_if    = idle && (locked ? !lock_ls : !pick_ls && bus.if_req);
  assign req       = sel_ls ? bus.ls_req : sel_if && bus.if_req;
  assign grant     = req && bus.mem_gnt;
  assign addr_mux  = sel_ls ? bus.ls_addr : sel_if ? bus.if_addr : '0;
  assign wdata_mux = sel_ls ? bus.ls_wdata : '0;
  assign bus.mem_req      = req;
  assign bus.mem_we       = sel_ls && bus.ls_we;
  assign bus.mem_be       = sel_ls ? bus.ls_be : sel_if ? 4'hF : 4'h0;
  assign bus.mem_addr     = addr_mux;
  assign bus.mem_wdata    = wdata_mux;
  assign bus.if_gnt       = sel_if && grant;
  assign bus.ls_gnt       = sel_ls && grant;
  assign bus.if_rvalid    = state == WAIT_IF && bus.mem_rvalid;
  assign bus.ls_rvalid    = state == WAIT_LS && bus.mem_rvalid;
  assign bus.if_rdata     = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ls_rdata     = bus.ls_rvalid ? bus.mem_rdata : '0;
  assign bus.stray_rvalid = idle && bus.mem_rvalid;
  always_comb begin
    state_nx   = state;
    locked_nx  = locked;
    lock_ls_nx = lock_ls;
    streak_nx  = streak;
    if (state == IDLE) begin
      if (grant) begin
        state_nx  = sel_ls ? WAIT_LS : WAIT_IF;
        locked_nx = 1'b0;
        streak_nx = sel_if ? 3'd0 : (!bus.if_req || streak == MAX) ? streak : streak + 3'd1;
      end else if (req) begin
        locked_nx  = 1'b1;
        lock_ls_nx = sel_ls;
      end
    end else if (bus.mem_rvalid) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      locked  <= 1'b0;
      lock_ls <= 1'b0;
      streak  <= 3'd0;
    end else begin
      state   <= state_nx;
      locked  <= locked_nx;
      lock_ls <= lock_ls_nx;
      streak  <= streak_nx;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory, transaction-level reference model
// feeding scoreboard queues that an independent monitor drains.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int MAXS = 4;
  typedef struct {bit ls; logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata;} req_t;
  typedef struct {bit ls; logic [31:0] data;} rsp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.XLEN(XLEN)) bus();
  mem_port_arbiter #(.XLEN(XLEN), .MAX_LS_STREAK(MAXS)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  req_t gnt_q[$];
  rsp_t rsp_q[$];
  bit   stray_q[$];
  bit   act_log[$];
  int   total = 0, bad = 0;
  int   p_if = 0, p_ls = 0, p_gnt = 100, dmin = 1, dmax = 1;
  bit   stray_now = 0, fix_ls = 0, if_seen = 0, ls_seen = 0;
  int   phase = 0, streak = 0, cnt = 0, if_grants = 0;
  req_t cur;
  logic [31:0] pc = 32'h0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    if (!bus.if_req || if_seen) begin
      bus.if_req  = $urandom_range(99) < p_if;
      bus.if_addr = bus.if_req ? pc : 32'h0;
      if (bus.if_req) pc += 4;
    end
    if (!bus.ls_req || ls_seen) begin
      bus.ls_req   = $urandom_range(99) < p_ls;
      bus.ls_we    = fix_ls ? 1'b1 : 1'($urandom_range(1));
      bus.ls_be    = fix_ls ? 4'b0011 : 4'($urandom_range(15));
      bus.ls_addr  = fix_ls ? 32'h2000 : ($urandom() & 32'hFFFFFFFC);
      bus.ls_wdata = fix_ls ? 32'hDEADBEEF : $urandom();
    end
    bus.mem_gnt    = $urandom_range(99) < p_gnt;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom();
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_fn(cur.addr);
      end
    end
    if (stray_now) bus.mem_rvalid = 1'b1;
  endtask

  // reference model: one decision per transaction, owner fixed until its grant
  task automatic observe();
    @(negedge clk);
    if_seen = bus.if_gnt;
    ls_seen = bus.ls_gnt;
    if (stray_now) stray_q.push_back(1'b1);
    if (phase == 0 && (bus.if_req || bus.ls_req)) begin
      cur.ls    = bus.ls_req && (!bus.if_req || streak < MAXS);
      cur.addr  = cur.ls ? bus.ls_addr : bus.if_addr;
      cur.we    = cur.ls && bus.ls_we;
      cur.be    = cur.ls ? bus.ls_be : 4'hF;
      cur.wdata = cur.ls ? bus.ls_wdata : 32'h0;
      gnt_q.push_back(cur);
      phase = 1;
    end
    if (phase == 1 && (bus.if_gnt || bus.ls_gnt)) begin
      streak = !cur.ls ? 0 : (bus.if_req && streak < MAXS) ? streak + 1 : streak;
      rsp_q.push_back('{cur.ls, mem_fn(cur.addr)});
      cnt = $urandom_range(dmax, dmin);
      act_log.push_back(bus.ls_gnt);
      if (bus.if_gnt) if_grants++;
      phase = 2;
    end else if (phase == 2 && bus.mem_rvalid) begin
      phase = 0;
    end
  endtask

  task automatic cycle();
    drive();
    observe();
  endtask

  task automatic drain();
    p_if = 0; p_ls = 0; p_gnt = 100;
    for (int i = 0; i < 100; i++) begin
      if (phase == 0 && !bus.if_req && !bus.ls_req && cnt == 0) return;
      cycle();
    end
    total++; bad++;
    $display("FAIL drain_timeout at %0t: phase=%0d", $time, phase);
  endtask

  initial begin
    req_t e;
    rsp_t r;
    bit   ex;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        chk("reset_outputs", 160'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.ls_gnt, bus.ls_rvalid,
            bus.ls_rdata, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
            bus.stray_rvalid}), 160'(0));
        continue;
      end
      if (bus.mem_req) begin
        if (gnt_q.size() == 0) chk("mem_req_unexpected", 160'(bus.mem_req), 160'(0));
        else begin
          e = gnt_q[0];
          chk("mem_fields", 160'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
              160'({e.we, e.be, e.addr, e.wdata}));
        end
      end
      if (bus.if_gnt || bus.ls_gnt) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", 160'({bus.if_gnt, bus.ls_gnt}), 160'(0));
        else begin
          e = gnt_q.pop_front();
          chk("gnt_owner", 160'({bus.if_gnt, bus.ls_gnt, bus.mem_gnt}), 160'({!e.ls, e.ls, 1'b1}));
        end
      end
      if (bus.if_rvalid || bus.ls_rvalid) begin
        if (rsp_q.size() == 0) chk("rvalid_unexpected", 160'({bus.if_rvalid, bus.ls_rvalid}), 160'(0));
        else begin
          r = rsp_q.pop_front();
          chk("rsp_owner_data", 160'({bus.if_rvalid, bus.ls_rvalid, r.ls ? bus.ls_rdata : bus.if_rdata,
              r.ls ? bus.if_rdata : bus.ls_rdata}), 160'({!r.ls, r.ls, r.data, 32'h0}));
        end
      end
      if (bus.stray_rvalid || stray_q.size() > 0) begin
        ex = stray_q.size() > 0;
        if (ex) void'(stray_q.pop_front());
        chk("stray", 160'(bus.stray_rvalid), 160'(ex));
      end
    end
  end

  initial begin
    {bus.if_req, bus.if_addr, bus.ls_req, bus.ls_we, bus.ls_be, bus.ls_addr, bus.ls_wdata} = '0;
    {bus.mem_gnt, bus.mem_rvalid, bus.mem_rdata} = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    // fetch only: one grant every two cycles
    drain();
    pc = 32'h100; p_if = 100; dmin = 1; dmax = 1; if_grants = 0;
    repeat (40) cycle();
    chk("fetch_rate", 160'(if_grants), 160'(20));
    // single store with fixed payload
    drain();
    fix_ls = 1; p_ls = 100;
    cycle();
    drain();
    fix_ls = 0;
    // starvation bound with both requesters saturated
    act_log.delete();
    p_if = 100; p_ls = 100;
    repeat (40) cycle();
    if (act_log.size() < 10) chk("starve_count", 160'(act_log.size()), 160'(10));
    else for (int i = 0; i < 10; i++) chk($sformatf("starve_seq_%0d", i), 160'(act_log[i]), 160'(i % 5 != 4));
    // lock: fetch stalled by memory, then load/store arrives
    drain();
    act_log.delete();
    p_if = 100; p_gnt = 0;
    repeat (3) cycle();
    p_ls = 100;
    cycle();
    p_if = 0; p_ls = 0; p_gnt = 100;
    repeat (3) cycle();
    if (act_log.size() == 0) chk("lock_no_grant", 160'(0), 160'(1));
    else chk("lock_first_grant_is_if", 160'(act_log[0]), 160'(0));
    // slow memory with both requests pending
    drain();
    p_if = 100; p_ls = 100; dmin = 5; dmax = 5;
    repeat (60) cycle();
    // randomized traffic
    drain();
    for (int k = 0; k < 12; k++) begin
      p_if = $urandom_range(100); p_ls = $urandom_range(100); p_gnt = $urandom_range(100, 30);
      dmin = 1; dmax = $urandom_range(6, 1);
      repeat (50) cycle();
    end
    // reset while a load/store is outstanding, then its late response
    drain();
    p_ls = 100; dmin = 20; dmax = 20;
    for (int i = 0; i < 20 && phase != 2; i++) cycle();
    p_ls = 0;
    repeat (2) cycle();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
    phase = 0; streak = 0; cnt = 0; if_seen = 0; ls_seen = 0;
    gnt_q.delete(); rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.mem_gnt = 1'b0;
    observe();
    dmin = 1; dmax = 3;
    stray_now = 1;
    cycle();
    stray_now = 0;
    p_if = 60; p_ls = 60; p_gnt = 70;
    repeat (100) cycle();
    drain();
    cycle();
    chk("gnt_q_drained", 160'(gnt_q.size()), 160'(0));
    chk("rsp_q_drained", 160'(rsp_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
